// File: rtl/if_fetch_if.sv
// Instruction bus between the fetch stage (master) and the instruction memory (slave).
// Single outstanding request; the ack is one cycle wide with read data in the same cycle.
interface if_fetch_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;

    modport master (
        output ibus_req,
        output ibus_addr,
        input  ibus_ack,
        input  ibus_rdata
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        output ibus_ack,
        output ibus_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs one bus transaction at a time and presents
// one instruction to IF/ID, dropping responses that a redirect has made stale.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    if_fetch_if.master  ibus,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;

    logic [31:0] w_next_pc;
    logic        w_unused_stall;

    // Only the IF/ID hold bit of the stall vector concerns this stage.
    assign w_unused_stall = ^{stall[5:2], stall[0]};

    assign w_next_pc = branch_flag_i ? branch_target_address_i : (r_if_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= 32'd0;
            r_if_pc    <= 32'd0;
            r_if_inst  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_pc <= new_pc;
                    end else begin
                        r_req_addr <= r_pc;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A flush never withdraws the request; an unacked one is drained in S_DROP.
                    if (flush) begin
                        r_pc    <= new_pc;
                        r_state <= ibus.ibus_ack ? S_IDLE : S_DROP;
                    end else if (ibus.ibus_ack) begin
                        r_if_pc   <= r_req_addr;
                        r_if_inst <= ibus.ibus_rdata;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        r_pc    <= new_pc;
                        r_state <= S_IDLE;
                    end else if (!stall[1]) begin
                        r_pc       <= w_next_pc;
                        r_req_addr <= w_next_pc;
                        r_state    <= S_BUSY;
                    end
                end
                S_DROP: begin
                    if (flush) begin
                        r_pc <= new_pc;
                    end else if (ibus.ibus_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus and stall outputs depend on registered state only, never on inputs.
    assign ibus.ibus_req  = (r_state == S_BUSY) || (r_state == S_DROP);
    assign ibus.ibus_addr = {r_req_addr[31:2], 2'b00};
    assign stallreq       = (r_state != S_HOLD);
    assign if_pc          = r_if_pc;
    assign if_inst        = r_if_inst;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle table for the listed scenarios, then a randomized
// run against an instruction-stream reference model with a random-latency bus slave.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus                    (bus),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq                (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] npc;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'd0) ? 32'h24010001 : ((a ^ 32'h5A5A_0000) + 32'h13);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] st, input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] tgt, input logic ack,
                       input logic e_req, input logic [31:0] e_addr, input logic e_sr,
                       input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.rst = r; v.st = st; v.fl = fl; v.npc = npc; v.br = br; v.tgt = tgt; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_sr = e_sr; v.e_pc = e_pc; v.e_inst = e_inst;
        vecs.push_back(v);
    endtask

    // Random-phase state
    int          cnt;
    int          wait_n;
    int          idle;
    int          presented;
    logic [31:0] exp_next;
    logic        pre_sr, pre_req;
    logic [31:0] pre_pc, pre_inst, pre_addr;
    logic [31:0] tmp;

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;
        bus.ibus_ack = 1'b0; bus.ibus_rdata = '0;

        //   rst st      fl npc           br tgt           ack | req addr          sr pc            inst
        add(0, 6'h00, 0, 32'h0,      0, 32'h0,        0,  0, 32'h0,        1, 32'h0,        32'h0);
        add(0, 6'h00, 0, 32'h0,      0, 32'h0,        0,  0, 32'h0,        1, 32'h0,        32'h0);
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h0,        1, 32'h0,        32'h0);
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        mem(32'h0));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h4,        1, 32'h0,        mem(32'h0));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h4,        0, 32'h4,        mem(32'h4));
        add(1, 6'h02, 0, 32'h0,      0, 32'h0,        0,  0, 32'h4,        0, 32'h4,        mem(32'h4));
        add(1, 6'h02, 0, 32'h0,      0, 32'h0,        0,  0, 32'h4,        0, 32'h4,        mem(32'h4));
        add(1, 6'h02, 0, 32'h0,      0, 32'h0,        0,  0, 32'h4,        0, 32'h4,        mem(32'h4));
        add(1, 6'h3D, 0, 32'h0,      0, 32'h0,        0,  1, 32'h8,        1, 32'h4,        mem(32'h4));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h8,        0, 32'h8,        mem(32'h8));
        add(1, 6'h00, 0, 32'h0,      1, 32'h100,      0,  1, 32'h100,      1, 32'h8,        mem(32'h8));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h100,      0, 32'h100,      mem(32'h100));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h104,      1, 32'h100,      mem(32'h100));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h104,      0, 32'h104,      mem(32'h104));
        add(1, 6'h00, 1, 32'h20,     0, 32'h0,        0,  0, 32'h104,      1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h20,       1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 1, 32'h180,    0, 32'h0,        0,  1, 32'h20,       1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h20,       1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h20,       1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h20,       1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h180,      1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 1, 32'h200,    0, 32'h0,        1,  0, 32'h180,      1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h200,      1, 32'h104,      mem(32'h104));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h200,      0, 32'h200,      mem(32'h200));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h204,      1, 32'h200,      mem(32'h200));
        add(0, 6'h00, 0, 32'h0,      0, 32'h0,        0,  0, 32'h0,        1, 32'h0,        32'h0);
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h0,        1, 32'h0,        32'h0);
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        mem(32'h0));
        add(1, 6'h00, 0, 32'h0,      1, 32'hFFFFFFFC, 0,  1, 32'hFFFFFFFC, 1, 32'h0,        mem(32'h0));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, mem(32'hFFFFFFFC));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        0,  1, 32'h0,        1, 32'hFFFFFFFC, mem(32'hFFFFFFFC));
        add(1, 6'h00, 0, 32'h0,      0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        mem(32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; stall = vecs[i].st; flush = vecs[i].fl; new_pc = vecs[i].npc;
            branch_flag_i = vecs[i].br; branch_target_address_i = vecs[i].tgt;
            bus.ibus_ack   = vecs[i].ack;
            bus.ibus_rdata = vecs[i].ack ? mem(bus.ibus_addr) : 32'hDEADBEEF;
            @(posedge clk); #1;
            chk($sformatf("vec%0d {req,addr,stallreq,if_pc,if_inst}", i),
                {30'd0, bus.ibus_req, bus.ibus_addr, stallreq, if_pc, if_inst},
                {30'd0, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_sr, vecs[i].e_pc, vecs[i].e_inst});
        end

        // Randomized run: fresh reset, then random stalls, branches, flushes and bus latency.
        rst = 1'b0; stall = '0; flush = 1'b0; branch_flag_i = 1'b0; bus.ibus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt = 0; wait_n = 0; idle = 0; presented = 0;
        exp_next = 32'h0;

        for (int n = 0; n < 3000; n++) begin
            tmp = $urandom; stall = tmp[5:0];
            stall[1] = ($urandom_range(0, 9) < 4);
            flush = ($urandom_range(0, 39) == 0);
            tmp = $urandom; new_pc = {tmp[31:2], 2'b00};
            branch_flag_i = ($urandom_range(0, 3) == 0);
            tmp = $urandom; branch_target_address_i = {tmp[31:2], 2'b00};
            bus.ibus_ack   = bus.ibus_req && (cnt >= wait_n);
            bus.ibus_rdata = bus.ibus_ack ? mem(bus.ibus_addr) : $urandom;

            pre_sr = stallreq; pre_pc = if_pc; pre_inst = if_inst;
            pre_req = bus.ibus_req; pre_addr = bus.ibus_addr;
            @(posedge clk); #1;

            if (pre_req && bus.ibus_ack) begin
                cnt = 0;
                wait_n = $urandom_range(0, 3);
            end else if (pre_req) begin
                cnt++;
            end

            if (flush) exp_next = new_pc;
            else if (!pre_sr && !stall[1]) exp_next = branch_flag_i ? branch_target_address_i : pre_pc + 32'd4;

            if (pre_req && !bus.ibus_ack)
                chk("bus_hold {req,addr}", {95'd0, bus.ibus_req, bus.ibus_addr}, {95'd0, 1'b1, pre_addr});

            if (!pre_sr) begin
                if (!flush && stall[1])
                    chk("ifid_hold {stallreq,pc,inst}", {63'd0, stallreq, if_pc, if_inst}, {63'd0, 1'b0, pre_pc, pre_inst});
                else
                    chk("leave_hold stallreq", {127'd0, stallreq}, {127'd0, 1'b1});
            end else if (!stallreq) begin
                chk("present {pc,inst}", {64'd0, if_pc, if_inst}, {64'd0, exp_next, mem(exp_next)});
                presented++;
                idle = 0;
            end

            if (stallreq) idle++;
            if (idle > 60) begin
                checks++; errors++;
                $display("FAIL fetch_timeout: stallreq high for %0d cycles, required at most 60", idle);
                break;
            end
        end

        chk("instructions_presented>=100", {127'd0, (presented >= 100)}, {127'd0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, runs a single-outstanding request/acknowledge transaction on the instruction bus, and presents one fetched instruction plus its address to the IF/ID pipeline register. It raises a stall request while no instruction is ready. It applies branch redirects from ID and flush redirects from the exception logic, and discards any bus response made stale by a redirect.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst == 0 at a rising edge resets the block)
- stall  in  6  pipeline stall vector from ctrl; only stall[1] (IF/ID hold) is used, other bits ignored
- flush  in  1  exception flush; highest-priority redirect
- new_pc  in  32  redirect target, valid with flush
- branch_flag_i  in  1  ID resolved a taken branch/jump
- branch_target_address_i  in  32  branch target, valid with branch_flag_i
- ibus_req  out  1  instruction bus request
- ibus_addr  out  32  request address, word aligned ({addr[31:2],2'b00})
- ibus_ack  in  1  one-cycle acknowledge; ibus_rdata valid in the same cycle
- ibus_rdata  in  32  instruction word
- if_pc  out  32  address of the presented instruction, to IF/ID
- if_inst  out  32  presented instruction, to IF/ID
- stallreq  out  1  to ctrl; high while no valid instruction is presented

## Operation
- Registers: state, pc (next fetch address), req_addr (address of the outstanding request), if_pc, if_inst.
- States:
  - S_IDLE: no request. stallreq=1.
  - S_BUSY: request outstanding. ibus_req=1, ibus_addr=req_addr, stallreq=1.
  - S_HOLD: instruction valid on if_pc/if_inst. ibus_req=0, stallreq=0.
  - S_DROP: stale request outstanding. ibus_req=1 with addr unchanged, stallreq=1.
- ibus_req, ibus_addr and stallreq are decoded from state and registers only. No combinational path from any input.
- Bus rule: once raised, ibus_req and ibus_addr stay stable until the ack cycle. A request is never withdrawn. Ack in the first req cycle is legal.
- Transitions (flush has priority over everything):
  - S_IDLE:
    - flush: pc<=new_pc, stay.
    - otherwise: req_addr<=pc, go S_BUSY.
  - S_BUSY, no ack:
    - flush: pc<=new_pc, go S_DROP.
    - otherwise: stay.
  - S_BUSY, ack:
    - flush: drop the data, pc<=new_pc, go S_IDLE.
    - otherwise: if_pc<=req_addr, if_inst<=ibus_rdata, go S_HOLD.
  - S_HOLD:
    - flush: pc<=new_pc, go S_IDLE. if_pc/if_inst hold; they are invalid because stallreq=1.
    - stall[1]==1: hold.
    - stall[1]==0 (hand-off; IF/ID captures this edge): next = branch_flag_i ? branch_target_address_i : if_pc+4 (mod 2^32). pc<=next, req_addr<=next, go S_BUSY.
  - S_DROP:
    - flush: pc<=new_pc, stay.
    - ack: discard ibus_rdata, go S_IDLE.
- Branches are sampled only at hand-off. ctrl stalls ID while stallreq is high, so a branch in ID stays asserted until hand-off. The instruction handed off in that cycle is the delay slot, and the next fetch is the target.
- Reset (rst==0), from any state including mid-transaction: state<=S_IDLE, pc<=RESET_PC, req_addr<=0, if_pc<=0, if_inst<=0. Resulting outputs: ibus_req=0, ibus_addr=0, stallreq=1. The bus slave is reset by the same rst and abandons any transaction.

## Timing
- First ibus_req is high 1 cycle after the first edge with rst==1.
- Zero-wait bus: ack in the first BUSY cycle, then S_HOLD the next cycle.
- Steady-state throughput with zero-wait bus and no stalls: 1 instruction per 2 cycles (BUSY, HOLD, BUSY, ...).
- N wait cycles add N cycles per instruction.
- Flush during BUSY without ack: refetch starts 1 cycle after the stale ack (DROP, IDLE, BUSY).
- Flush during HOLD or IDLE: new request 1 cycle later.
- Address arithmetic is 32-bit; 32'hFFFFFFFC+4 wraps to 0.

## Test plan
- Reset then zero-wait bus returning 32'h24010001 at 0: ibus_req rises 1 cycle after rst deasserts with ibus_addr=0. Next cycle if_pc=0, if_inst=32'h24010001, stallreq=0. The following request is to 4.
- Hold: stall[1]=1 for 3 cycles in S_HOLD: if_pc/if_inst stable, ibus_req=0. After release, the next request is to if_pc+4.
- Branch: branch_flag_i=1, target 32'h100, at hand-off of pc 8: next ibus_addr=32'h100, not 12.
- Flush mid-fetch: ack delayed 3 cycles at addr 32'h20, flush with new_pc=32'h180 in cycle 1: ibus_addr stays 32'h20 until ack, the stale data never reaches if_inst, the next request is to 32'h180, and stallreq stays 1 throughout.
- Flush coincident with ack: data dropped, the request to new_pc is issued 1 cycle later.
- Reset asserted during S_BUSY: the next cycle ibus_req=0, if_pc=if_inst=0, and fetch restarts at RESET_PC.
